// File: rtl/mod_group_ctrl.sv
// Packs scrambled bits MSB-first into Qm-bit groups (BPSK/QPSK/16QAM/64QAM) for the modulation mapper.
// Latency: group valid 1 cycle after its Qm-th bit is accepted; Frame_Done 1 cycle after the last handshake.
// Backpressure: SC_Ready drops while a group waits for Mod_Ready; Mod_Bits/Mod_Last hold until the handshake.
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-low reset
//   Start, Mod_Sel,   frame start request (IDLE only) with modulation order and symbol count,
//   Num_Sym             both latched on an accepted Start
//   Abort             synchronous abort, returns to IDLE next cycle, overrides everything
//   SC_IN/_Valid/_Ready   scrambled bit input, one bit per accepting cycle
//   Mod_Bits/_Valid/_Ready/_Last  packed group output to the mapper
//   Busy, Frame_Done, Cfg_Err     status: not idle, end-of-frame pulse, zero-length-start pulse
module mod_group_ctrl #(
  parameter int LEN_W = 16,
  parameter int MAXQ  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Mod_Sel,
  input  logic [LEN_W-1:0] Num_Sym,
  input  logic             Abort,
  input  logic             SC_IN,
  input  logic             SC_Valid,
  output logic             SC_Ready,
  output logic [MAXQ-1:0]  Mod_Bits,
  output logic             Mod_Valid,
  input  logic             Mod_Ready,
  output logic             Mod_Last,
  output logic             Busy,
  output logic             Frame_Done,
  output logic             Cfg_Err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       qm, qm_dec;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] num_sym, sym_cnt;
  logic [MAXQ-1:0]  shreg, shreg_nxt, mod_bits_q;
  logic             start_ok, cfg_bad, bit_acc, group_done, hs, is_last;

  always_comb begin
    qm_dec = 3'd1;
    case (Mod_Sel)
      2'b00:   qm_dec = 3'd1;
      2'b01:   qm_dec = 3'd2;
      2'b10:   qm_dec = 3'd4;
      default: qm_dec = 3'd6;
    endcase
  end

  // Shifting left places the first bit of a group at [Qm-1] once Qm bits are in;
  // shreg is cleared at each group start so the upper bits stay zero.
  assign shreg_nxt = {shreg[MAXQ-2:0], SC_IN};

  // num_sym is never zero inside a frame, so num_sym-1 cannot underflow there.
  assign is_last = (state == EMIT) && (sym_cnt == num_sym - LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    SC_Ready   = 1'b0;
    Mod_Valid  = 1'b0;
    start_ok   = 1'b0;
    cfg_bad    = 1'b0;
    bit_acc    = 1'b0;
    group_done = 1'b0;
    hs         = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          if (Num_Sym != '0) begin
            start_ok  = 1'b1;
            state_nxt = ACCUM;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      ACCUM: begin
        SC_Ready   = 1'b1;
        bit_acc    = SC_Valid;
        group_done = SC_Valid && ((bit_cnt + 3'd1) == qm);
        if (group_done) state_nxt = EMIT;
      end
      EMIT: begin
        Mod_Valid = 1'b1;
        hs        = Mod_Ready;
        if (Mod_Ready) state_nxt = is_last ? IDLE : ACCUM;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over Start and over any handshake in the same cycle.
    if (Abort) begin
      state_nxt  = IDLE;
      start_ok   = 1'b0;
      cfg_bad    = 1'b0;
      bit_acc    = 1'b0;
      group_done = 1'b0;
      hs         = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      qm         <= 3'd1;
      num_sym    <= '0;
      sym_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      mod_bits_q <= '0;
      Frame_Done <= 1'b0;
      Cfg_Err    <= 1'b0;
    end else begin
      Frame_Done <= 1'b0;
      Cfg_Err    <= cfg_bad;
      if (Abort) begin
        sym_cnt    <= '0;
        bit_cnt    <= '0;
        shreg      <= '0;
        mod_bits_q <= '0;
      end else begin
        if (start_ok) begin
          qm      <= qm_dec;
          num_sym <= Num_Sym;
          sym_cnt <= '0;
          bit_cnt <= '0;
          shreg   <= '0;
        end
        if (bit_acc) begin
          if (group_done) begin
            mod_bits_q <= shreg_nxt;
            shreg      <= '0;
            bit_cnt    <= '0;
          end else begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        if (hs) begin
          sym_cnt <= sym_cnt + LEN_W'(1);
          if (is_last) Frame_Done <= 1'b1;
        end
      end
    end
  end

  assign Mod_Bits = mod_bits_q;
  assign Mod_Last = is_last;
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_mod_group_ctrl.sv
// Directed bench for mod_group_ctrl: reset, QPSK stream, 64QAM stall, BPSK bubbles, abort, config errors.
// Latency: inputs driven #1 after the rising edge, outputs sampled #1 after the next rising edge.
// Backpressure: Mod_Ready is held low in the stall scenario to exercise output hold.
module tb_mod_group_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Mod_Sel = 2'b00;
  logic [15:0] Num_Sym = 16'd0;
  logic        Abort = 1'b0;
  logic        SC_IN = 1'b0;
  logic        SC_Valid = 1'b0;
  logic        SC_Ready;
  logic [5:0]  Mod_Bits;
  logic        Mod_Valid;
  logic        Mod_Ready = 1'b0;
  logic        Mod_Last;
  logic        Busy;
  logic        Frame_Done;
  logic        Cfg_Err;

  int checks = 0;
  int errors = 0;

  mod_group_ctrl #(.LEN_W(16), .MAXQ(6)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Mod_Sel(Mod_Sel), .Num_Sym(Num_Sym),
    .Abort(Abort), .SC_IN(SC_IN), .SC_Valid(SC_Valid), .SC_Ready(SC_Ready),
    .Mod_Bits(Mod_Bits), .Mod_Valid(Mod_Valid), .Mod_Ready(Mod_Ready),
    .Mod_Last(Mod_Last), .Busy(Busy), .Frame_Done(Frame_Done), .Cfg_Err(Cfg_Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] sel, input logic [15:0] n);
    Start = 1'b1; Mod_Sel = sel; Num_Sym = n;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; Start = 1'b1; SC_Valid = 1'b1; SC_IN = 1'b1; Num_Sym = 16'd5;
    repeat (3) tick();
    checks++;
    if ({SC_Ready, Mod_Valid, Mod_Last, Busy, Frame_Done, Cfg_Err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b need 000000",
               {SC_Ready, Mod_Valid, Mod_Last, Busy, Frame_Done, Cfg_Err});
    end
    checks++;
    if (Mod_Bits !== 6'b0) begin
      errors++; $display("FAIL reset_bits got %b need 000000", Mod_Bits);
    end
    RST = 1'b1; Start = 1'b0; SC_Valid = 1'b0; SC_IN = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0 || SC_Ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b rdy=%b need 0 0", Busy, SC_Ready);
    end
  endtask

  task automatic test_qpsk();
    logic [5:0] bits = 6'b100111;
    logic [5:0] exp [3];
    exp[0] = 6'b000010; exp[1] = 6'b000001; exp[2] = 6'b000011;
    Mod_Ready = 1'b1;
    start_frame(2'b01, 16'd3);
    checks++;
    if (Busy !== 1'b1 || SC_Ready !== 1'b1) begin
      errors++; $display("FAIL qpsk_start got busy=%b rdy=%b need 1 1", Busy, SC_Ready);
    end
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 2; b++) begin
        SC_Valid = 1'b1; SC_IN = bits[5 - (2*g + b)];
        tick();
      end
      SC_Valid = 1'b0;
      checks++;
      if (Mod_Valid !== 1'b1 || Mod_Bits !== exp[g] || Mod_Last !== (g == 2) || SC_Ready !== 1'b0) begin
        errors++;
        $display("FAIL qpsk_group%0d got v=%b bits=%b last=%b rdy=%b need 1 %b %b 0",
                 g, Mod_Valid, Mod_Bits, Mod_Last, SC_Ready, exp[g], (g == 2));
      end
      tick();
      checks++;
      if (Mod_Valid !== 1'b0 || Frame_Done !== (g == 2)) begin
        errors++;
        $display("FAIL qpsk_after%0d got v=%b done=%b need 0 %b", g, Mod_Valid, Frame_Done, (g == 2));
      end
    end
    tick();
    checks++;
    if (Frame_Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL qpsk_done_pulse got done=%b busy=%b need 0 0", Frame_Done, Busy);
    end
  endtask

  task automatic test_64qam_stall();
    logic [5:0] bits = 6'b101100;
    Mod_Ready = 1'b0;
    start_frame(2'b11, 16'd1);
    for (int b = 0; b < 6; b++) begin
      SC_Valid = 1'b1; SC_IN = bits[5 - b];
      tick();
    end
    // Keep offering bits during the stall; none may be taken.
    SC_IN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b101100 || Mod_Last !== 1'b1 || SC_Ready !== 1'b0) begin
        errors++;
        $display("FAIL qam64_stall%0d got v=%b bits=%b last=%b rdy=%b need 1 101100 1 0",
                 c, Mod_Valid, Mod_Bits, Mod_Last, SC_Ready);
      end
      tick();
    end
    Mod_Ready = 1'b1;
    checks++;
    if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b101100) begin
      errors++; $display("FAIL qam64_pre_hs got v=%b bits=%b need 1 101100", Mod_Valid, Mod_Bits);
    end
    tick();
    checks++;
    if (Frame_Done !== 1'b1 || Busy !== 1'b0 || SC_Ready !== 1'b0) begin
      errors++;
      $display("FAIL qam64_done got done=%b busy=%b rdy=%b need 1 0 0", Frame_Done, Busy, SC_Ready);
    end
    SC_Valid = 1'b0;
    tick();
  endtask

  task automatic test_bpsk_bubbles();
    logic [3:0] bits = 4'b1011;
    Mod_Ready = 1'b1;
    start_frame(2'b00, 16'd4);
    for (int s = 0; s < 4; s++) begin
      SC_Valid = 1'b0;
      tick();
      checks++;
      if (Mod_Valid !== 1'b0 || SC_Ready !== 1'b1) begin
        errors++; $display("FAIL bpsk_bubble%0d got v=%b rdy=%b need 0 1", s, Mod_Valid, SC_Ready);
      end
      SC_Valid = 1'b1; SC_IN = bits[3 - s];
      tick();
      SC_Valid = 1'b0;
      checks++;
      if (Mod_Valid !== 1'b1 || Mod_Bits !== {5'b0, bits[3 - s]} || Mod_Last !== (s == 3)) begin
        errors++;
        $display("FAIL bpsk_sym%0d got v=%b bits=%b last=%b need 1 %b %b",
                 s, Mod_Valid, Mod_Bits, Mod_Last, {5'b0, bits[3 - s]}, (s == 3));
      end
      tick();
    end
    checks++;
    if (Frame_Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL bpsk_done got done=%b busy=%b need 1 0", Frame_Done, Busy);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] bits = 8'b10101110;
    Mod_Ready = 1'b1;
    start_frame(2'b10, 16'd2);
    for (int b = 0; b < 4; b++) begin
      SC_Valid = 1'b1; SC_IN = bits[7 - b];
      tick();
    end
    SC_Valid = 1'b0;
    checks++;
    if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b001010 || Mod_Last !== 1'b0) begin
      errors++;
      $display("FAIL abort_g0 got v=%b bits=%b last=%b need 1 001010 0", Mod_Valid, Mod_Bits, Mod_Last);
    end
    tick();
    for (int b = 4; b < 7; b++) begin
      SC_Valid = 1'b1; SC_IN = bits[7 - b];
      tick();
    end
    // Abort together with the bit that would complete the group.
    Abort = 1'b1; SC_IN = bits[0];
    tick();
    Abort = 1'b0; SC_Valid = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Mod_Valid !== 1'b0 || SC_Ready !== 1'b0 || Mod_Last !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b v=%b rdy=%b last=%b need 0 0 0 0",
               Busy, Mod_Valid, SC_Ready, Mod_Last);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (Frame_Done !== 1'b0 || Mod_Valid !== 1'b0) begin
        errors++; $display("FAIL abort_quiet%0d got done=%b v=%b need 0 0", c, Frame_Done, Mod_Valid);
      end
    end
    start_frame(2'b01, 16'd1);
    SC_Valid = 1'b1; SC_IN = 1'b0; tick();
    checks++;
    if (Mod_Valid !== 1'b0) begin
      errors++; $display("FAIL abort_partial_cleared got v=%b need 0", Mod_Valid);
    end
    SC_IN = 1'b1; tick();
    SC_Valid = 1'b0;
    checks++;
    if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b000001 || Mod_Last !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got v=%b bits=%b last=%b need 1 000001 1", Mod_Valid, Mod_Bits, Mod_Last);
    end
    tick();
    checks++;
    if (Frame_Done !== 1'b1) begin
      errors++; $display("FAIL abort_restart_done got %b need 1", Frame_Done);
    end
    tick();
  endtask

  task automatic test_cfg_err();
    Start = 1'b1; Num_Sym = 16'd0; Mod_Sel = 2'b01;
    tick();
    Start = 1'b0;
    checks++;
    if (Cfg_Err !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL cfg_err_pulse got err=%b busy=%b need 1 0", Cfg_Err, Busy);
    end
    tick();
    checks++;
    if (Cfg_Err !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL cfg_err_clear got err=%b busy=%b need 0 0", Cfg_Err, Busy);
    end
    // QPSK frame of 2 symbols; Start stays high with new settings mid-frame.
    Mod_Ready = 1'b1;
    start_frame(2'b01, 16'd2);
    Start = 1'b1; Mod_Sel = 2'b00; Num_Sym = 16'd0;
    SC_Valid = 1'b1; SC_IN = 1'b1; tick();
    checks++;
    if (Mod_Valid !== 1'b0 || Cfg_Err !== 1'b0) begin
      errors++; $display("FAIL restart_ignored got v=%b err=%b need 0 0", Mod_Valid, Cfg_Err);
    end
    SC_IN = 1'b1; tick();
    SC_Valid = 1'b0;
    checks++;
    if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b000011 || Mod_Last !== 1'b0) begin
      errors++;
      $display("FAIL restart_g0 got v=%b bits=%b last=%b need 1 000011 0", Mod_Valid, Mod_Bits, Mod_Last);
    end
    tick();
    SC_Valid = 1'b1; SC_IN = 1'b0; tick();
    SC_IN = 1'b1; tick();
    SC_Valid = 1'b0; Start = 1'b0;
    checks++;
    if (Mod_Valid !== 1'b1 || Mod_Bits !== 6'b000001 || Mod_Last !== 1'b1 || Cfg_Err !== 1'b0) begin
      errors++;
      $display("FAIL restart_g1 got v=%b bits=%b last=%b err=%b need 1 000001 1 0",
               Mod_Valid, Mod_Bits, Mod_Last, Cfg_Err);
    end
    tick();
    checks++;
    if (Frame_Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL restart_done got done=%b busy=%b need 1 0", Frame_Done, Busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_64qam_stall();
    test_bpsk_bubbles();
    test_abort();
    test_cfg_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
